counter_core: RTL and testbench
===============================

# counter_core

Parameterisable binary up-counter with terminal-count, wrap pulse and Gray-coded outputs. It is the timing/sequence source for the TinyTapeout counter top level and is reused wherever a free-running modulo-2^BW count is needed. Optional synchronous controls (enable, clear, load) are compiled in with a macro; without them the counter free-runs after reset.

## Interface
- BW, default 8: counter width in bits, BW >= 2; the top level instantiates BW = 3.

- clk_i  input  1  single clock, all state updates on the rising edge.
- rst_i  input  1  reset: asynchronous, active-low. Asserting it clears all state immediately; release is sampled on clk_i.
- en_i  input  1  count enable, only present with COUNTER_CTRL_EN.
- clr_i  input  1  synchronous clear to 0, only present with COUNTER_CTRL_EN.
- load_i  input  1  synchronous load of load_val_i, only present with COUNTER_CTRL_EN.
- load_val_i  input  BW  value to load, only present with COUNTER_CTRL_EN.
- counter_val_o  output  BW  registered count value.
- tc_o  output  1  terminal count, high while counter_val_o is all-ones; combinational from the count register.
- wrap_o  output  1  registered one-cycle pulse marking a rollover from all-ones to 0.
- gray_o  output  BW  Gray code of counter_val_o, computed as counter_val_o XOR (counter_val_o >> 1).

## Operation
- Reset (rst_i = 0): counter_val_o = 0, wrap_o = 0, tc_o = 0, gray_o = 0, held for as long as rst_i is low.
- Arithmetic is unsigned modulo 2^BW. The increment from 2^BW-1 goes to 0, with no saturation.
- Free-running mode (macro off): every rising clk_i with rst_i high, counter_val_o <= counter_val_o + 1.
- Controlled mode (macro on), priority per edge is clr_i > load_i > en_i > hold:
  - clr_i = 1: count <= 0.
  - else load_i = 1: count <= load_val_i.
  - else en_i = 1: count <= count + 1.
  - else: count holds.
- wrap_o is 1 in the cycle after an increment from all-ones to 0. It is 0 after any clear, load or hold, even if the result is 0.
- tc_o and gray_o follow the count register combinationally and have no extra state.

## Timing
- Latency is one clock from a control input to counter_val_o, wrap_o, tc_o and gray_o.
- First increment: with rst_i released before edge N, edge N produces counter_val_o = 1.
- Reset mid-count forces 0 asynchronously without waiting for a clock edge. Counting resumes from 0 at the first edge after release.
- Releasing rst_i coincident with a clk_i edge does not count on that edge; the next edge yields 1.
- A full period of 2^BW enabled edges returns the counter to its start value. wrap_o pulses once per period.

## Configuration
- COUNTER_CTRL_EN defined: the en_i, clr_i, load_i and load_val_i ports exist, and the controlled-mode rules above apply.
- COUNTER_CTRL_EN undefined: those ports do not exist and the counter increments on every edge out of reset. Outputs are otherwise identical.

## Test plan
- Reset: BW = 3, hold rst_i = 0 for 3 edges, then release. Requires counter_val_o = 0, wrap_o = 0, tc_o = 0 during reset, then 1, 2 … 7 on successive edges.
- Wrap: BW = 3, 40 free-running edges. Requires the sequence 0..7 to repeat 5 times, tc_o high only at value 7, and wrap_o high only in each cycle showing 0 after 7 (5 pulses).
- Gray: BW = 3, check gray_o at every value. Requires 0,1,3,2,6,7,5,4 for values 0..7, with exactly one bit changing per increment.
- Asynchronous reset mid-count: pull rst_i low between edges at value 5. Requires counter_val_o = 0 before the next edge, and counting to resume at 1 after release.
- Controls (macro on, BW = 3):
  - en_i = 0 for 4 edges: the count holds.
  - load_i with load_val_i = 6: the count becomes 6, then 7 with tc_o = 1, then 0 with wrap_o = 1.
- Control priority (macro on): clr_i, load_i and en_i all asserted together. Requires count = 0 and wrap_o = 0. Loading 7 requires tc_o = 1 and wrap_o = 0.

Source files
------------

// File: rtl/counter_core.sv
// counter_core: modulo-2^BW up-counter with terminal count, wrap pulse and Gray output.
// Define COUNTER_CTRL_EN to add the synchronous enable/clear/load controls.
module counter_core #(
    parameter int BW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
`ifdef COUNTER_CTRL_EN
    input  logic          en_i,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [BW-1:0] load_val_i,
`endif
    output logic [BW-1:0] counter_val_o,
    output logic          tc_o,
    output logic          wrap_o,
    output logic [BW-1:0] gray_o
);

    localparam logic [BW-1:0] ALL_ONES = {BW{1'b1}};
    localparam logic [BW-1:0] ONE      = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0] ZERO     = {BW{1'b0}};

    function automatic logic [BW-1:0] bin2gray(input logic [BW-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    logic [BW-1:0] count_r;
    logic          wrap_r;
    logic [BW-1:0] count_nxt_s;
    logic          wrap_nxt_s;
    logic [BW-1:0] count_inc_s;
    logic          at_top_s;

    assign count_inc_s = count_r + ONE;
    assign at_top_s    = (count_r == ALL_ONES);

    // Next count and wrap flag; wrap is only raised by an increment out of all-ones
    always_comb begin
        count_nxt_s = count_r;
        wrap_nxt_s  = 1'b0;
`ifdef COUNTER_CTRL_EN
        if (clr_i) begin
            count_nxt_s = ZERO;
            wrap_nxt_s  = 1'b0;
        end else if (load_i) begin
            count_nxt_s = load_val_i;
            wrap_nxt_s  = 1'b0;
        end else if (en_i) begin
            count_nxt_s = count_inc_s;
            wrap_nxt_s  = at_top_s;
        end else begin
            count_nxt_s = count_r;
            wrap_nxt_s  = 1'b0;
        end
`else
        count_nxt_s = count_inc_s;
        wrap_nxt_s  = at_top_s;
`endif
    end

    // Count and wrap registers, cleared asynchronously by reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_r <= ZERO;
            wrap_r  <= 1'b0;
        end else begin
            count_r <= count_nxt_s;
            wrap_r  <= wrap_nxt_s;
        end
    end

    assign counter_val_o = count_r;
    assign wrap_o        = wrap_r;
    assign tc_o          = at_top_s;
    assign gray_o        = bin2gray(count_r);

endmodule

// File: tb/tb_counter_core.sv
// Self-checking bench for counter_core (BW = 3), randomized against a behavioural model.
module tb_counter_core;
    localparam int BW   = 3;
    localparam int MODV = 1 << BW;
    localparam int MAXV = MODV - 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
`ifdef COUNTER_CTRL_EN
    logic          en_i = 1'b1;
    logic          clr_i = 1'b0;
    logic          load_i = 1'b0;
    logic [BW-1:0] load_val_i = '0;
`endif
    logic [BW-1:0] counter_val_o;
    logic          tc_o;
    logic          wrap_o;
    logic [BW-1:0] gray_o;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_cnt  = 0;
    int exp_wrap = 0;
    int gray_tab [8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    counter_core #(.BW(BW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
`ifdef COUNTER_CTRL_EN
        .en_i          (en_i),
        .clr_i         (clr_i),
        .load_i        (load_i),
        .load_val_i    (load_val_i),
`endif
        .counter_val_o (counter_val_o),
        .tc_o          (tc_o),
        .wrap_o        (wrap_o),
        .gray_o        (gray_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".val"},  int'(counter_val_o), exp_cnt);
        check_eq({tag, ".wrap"}, int'(wrap_o), exp_wrap);
        check_eq({tag, ".tc"},   int'(tc_o), (exp_cnt == MAXV) ? 1 : 0);
        check_eq({tag, ".gray"}, int'(gray_o), gray_tab[exp_cnt]);
    endtask

    // One clock edge: advance the model from the inputs seen at the edge, then compare
    task automatic step(input string tag);
        @(posedge clk_i);
        if (!rst_i) begin
            exp_cnt = 0; exp_wrap = 0;
        end else begin
`ifdef COUNTER_CTRL_EN
            if (clr_i) begin
                exp_cnt = 0; exp_wrap = 0;
            end else if (load_i) begin
                exp_cnt = int'(load_val_i); exp_wrap = 0;
            end else if (en_i) begin
                exp_wrap = (exp_cnt == MAXV) ? 1 : 0;
                exp_cnt  = (exp_cnt + 1) % MODV;
            end else begin
                exp_wrap = 0;
            end
`else
            exp_wrap = (exp_cnt == MAXV) ? 1 : 0;
            exp_cnt  = (exp_cnt + 1) % MODV;
`endif
        end
        #1;
        check_outputs(tag);
    endtask

    // Reset pulse between edges: outputs must clear before any further edge
    task automatic mid_reset(input string tag);
        #2 rst_i = 1'b0;
        #1;
        exp_cnt = 0; exp_wrap = 0;
        check_outputs(tag);
        #2 rst_i = 1'b1;
    endtask

    initial begin
        int wraps;
        int tcs;
        int prev_gray;
        int guard;

        // Reset held for three edges, then count 1..7
        for (int i = 0; i < 3; i++) step("reset_hold");
        rst_i = 1'b1;
        for (int i = 1; i <= MAXV; i++) begin
            step("first_count");
            check_eq("first_count.seq", int'(counter_val_o), i);
        end

        // Forty free-running edges: five wraps, tc only at 7, single-bit Gray steps
        wraps = 0; tcs = 0;
        prev_gray = int'(gray_o);
        for (int i = 0; i < 40; i++) begin
            step("free_run");
            wraps += int'(wrap_o);
            tcs   += int'(tc_o);
            check_eq("gray_onebit", $countones(int'(gray_o) ^ prev_gray), 1);
            prev_gray = int'(gray_o);
        end
        check_eq("wrap_pulses", wraps, 5);
        check_eq("tc_cycles", tcs, 5);

        // Asynchronous reset at value 5, then resume from 1
        guard = 0;
        while (exp_cnt != 5 && guard < 2 * MODV) begin
            step("seek5");
            guard++;
        end
        check_eq("reached5", int'(counter_val_o), 5);
        mid_reset("async_rst");
        step("resume");
        check_eq("resume_at1", int'(counter_val_o), 1);

`ifdef COUNTER_CTRL_EN
        // Hold for four edges
        en_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step("hold");
            check_eq("hold_val", int'(counter_val_o), 1);
        end
        // Load 6 then count through 7 and wrap
        load_i = 1'b1; load_val_i = 3'd6;
        step("load6");
        check_eq("load6_val", int'(counter_val_o), 6);
        load_i = 1'b0; en_i = 1'b1;
        step("after_load7");
        check_eq("load7_tc", int'(tc_o), 1);
        step("after_load_wrap");
        check_eq("load_wrap", int'(wrap_o), 1);
        // Clear beats load and enable
        clr_i = 1'b1; load_i = 1'b1; en_i = 1'b1; load_val_i = 3'd5;
        step("prio");
        check_eq("prio_val", int'(counter_val_o), 0);
        check_eq("prio_wrap", int'(wrap_o), 0);
        clr_i = 1'b0; load_val_i = 3'd7;
        step("load7");
        check_eq("load7_tc2", int'(tc_o), 1);
        check_eq("load7_wrap", int'(wrap_o), 0);
        load_i = 1'b0;
`endif

        // Randomized run with occasional asynchronous reset pulses
        for (int i = 0; i < 300; i++) begin
`ifdef COUNTER_CTRL_EN
            clr_i      = ($urandom_range(0, 15) == 0);
            load_i     = ($urandom_range(0, 7) == 0);
            en_i       = ($urandom_range(0, 3) != 0);
            load_val_i = BW'($urandom_range(0, MAXV));
`endif
            step("random");
            if ($urandom_range(0, 24) == 0) mid_reset("random_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
